// File: rtl/operand_entry_ctrl_if.sv
// Board-side bundle for the operand-entry front-end: raw switches/buttons in,
// ALU drive signals and state LEDs out.
interface operand_entry_ctrl_if #(parameter int DATA_W = 4);
  logic [DATA_W-1:0] sw;
  logic              btn_confirm;
  logic              btn_op;
  logic              btn_clear;
  logic              enable;
  logic              select;
  logic [DATA_W-1:0] input_a;
  logic [DATA_W-1:0] input_b;
  logic [1:0]        state_led;

  modport master (
    output sw, btn_confirm, btn_op, btn_clear,
    input  enable, select, input_a, input_b, state_led
  );

  modport slave (
    input  sw, btn_confirm, btn_op, btn_clear,
    output enable, select, input_a, input_b, state_led
  );
endinterface

// File: rtl/operand_entry_ctrl.sv
// Button debounce lanes plus the operand-entry FSM that latches switch values
// as ALU operands and drives enable/select for the add/sub datapath.

module operand_entry_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_i,
  output logic deb_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             deb_q;

  // Any return to the accepted level restarts the hold window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else if (sync_i == deb_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_q <= sync_i;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign deb_o = deb_q;
endmodule

module operand_entry_ctrl #(
  parameter int DATA_W          = 4,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int CNT_W           = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  operand_entry_ctrl_if.slave  io
);
  localparam int NB = 3;  // 0 confirm, 1 op, 2 clear

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_RUN = 2'b10
  } state_e;

  logic [NB-1:0]     btn_raw, btn_s1_q, btn_s2_q, deb, deb_d1_q, press;
  logic [DATA_W-1:0] sw_s1_q, sw_s2_q;
  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;

  assign btn_raw = {io.btn_clear, io.btn_op, io.btn_confirm};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      deb_d1_q <= '0;
    end else begin
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= io.sw;
      sw_s2_q  <= sw_s1_q;
      deb_d1_q <= deb;
    end
  end

  operand_entry_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db [NB-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .sync_i(btn_s2_q),
    .deb_o (deb)
  );

  // Rising edge of the debounced level only; releases are silent.
  assign press = deb & ~deb_d1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      sel_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (press[2]) begin
      state_d = S_A;
    end else if (press[0]) begin
      case (state_q)
        S_A:     state_d = S_B;
        S_B:     state_d = S_RUN;
        default: state_d = S_A;
      endcase
    end else if (state_q != S_A && state_q != S_B && state_q != S_RUN) begin
      state_d = S_A;
    end
  end

  // Clear wins over confirm, confirm over op; an op in the same cycle is dropped.
  always_comb begin
    sel_d = sel_q;
    a_d   = a_q;
    b_d   = b_q;
    if (press[2]) begin
      sel_d = 1'b0;
      a_d   = '0;
      b_d   = '0;
    end else if (press[0]) begin
      if (state_q == S_A) a_d = sw_s2_q;
      if (state_q == S_B) b_d = sw_s2_q;
    end else if (press[1] && state_q == S_RUN) begin
      sel_d = ~sel_q;
    end
  end

  always_comb begin
    io.enable    = (state_q == S_RUN);
    io.state_led = state_q;
    io.select    = sel_q;
    io.input_a   = a_q;
    io.input_b   = b_q;
  end
endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed scenarios plus random button/switch traffic against a behavioural
// model of the operand-entry front-end.
module tb_operand_entry_ctrl;
  localparam int DW = 4;
  localparam int DC = 4;
  localparam int CW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  operand_entry_ctrl_if #(.DATA_W(DW)) io ();

  operand_entry_ctrl #(
    .DATA_W(DW), .DEBOUNCE_CYCLES(DC), .CNT_W(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  int checks   = 0;
  int failures = 0;

  // Model: raw button samples per edge (index = edges ago), switch samples,
  // accepted button levels, and the operand-entry state.
  logic [2:0]    rh [0:15];
  logic [DW-1:0] swh [0:2];
  logic [2:0]    deb_m, debp_m;
  int            st_m;
  logic          sel_m;
  logic [DW-1:0] a_m, b_m;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) rh[i] = '0;
    for (int i = 0; i < 3; i++) swh[i] = '0;
    deb_m = '0; debp_m = '0;
    st_m = 0; sel_m = 1'b0; a_m = '0; b_m = '0;
  endtask

  // A button is accepted once its synchronised level (two edges late) has
  // disagreed with the accepted level for DC consecutive edges.
  task automatic model_edge();
    logic [2:0]    p;
    logic [DW-1:0] sws;
    logic          allv;
    p   = deb_m & ~debp_m;
    sws = swh[1];
    if (p[2]) begin
      st_m = 0; sel_m = 1'b0; a_m = '0; b_m = '0;
    end else if (p[0]) begin
      if (st_m == 0) begin a_m = sws; st_m = 1; end
      else if (st_m == 1) begin b_m = sws; st_m = 2; end
      else st_m = 0;
    end else if (p[1] && st_m == 2) begin
      sel_m = ~sel_m;
    end
    for (int i = 15; i > 0; i--) rh[i] = rh[i-1];
    rh[0] = {io.btn_clear, io.btn_op, io.btn_confirm};
    swh[2] = swh[1]; swh[1] = swh[0]; swh[0] = io.sw;
    debp_m = deb_m;
    for (int b = 0; b < 3; b++) begin
      allv = 1'b1;
      for (int j = 2; j <= DC + 1; j++) if (rh[j][b] == deb_m[b]) allv = 1'b0;
      if (allv) deb_m[b] = ~deb_m[b];
    end
  endtask

  function automatic logic [31:0] exp_out();
    logic [1:0] s;
    s = 2'(st_m);
    return 32'({(st_m == 2), sel_m, a_m, b_m, s});
  endfunction

  function automatic logic [31:0] dut_out();
    return 32'({io.enable, io.select, io.input_a, io.input_b, io.state_led});
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    chk("outputs", dut_out(), exp_out());
  endtask

  task automatic set_btn(logic [2:0] m);
    io.btn_confirm = m[0];
    io.btn_op      = m[1];
    io.btn_clear   = m[2];
  endtask

  task automatic press(logic [2:0] m, int hold);
    set_btn(m);
    repeat (hold) tick();
    set_btn(3'b000);
    repeat (8) tick();
  endtask

  task automatic press_measure(string tag, int exp_lat);
    logic [1:0] l0;
    int n;
    l0 = io.state_led;
    n  = 0;
    set_btn(3'b001);
    do begin
      tick();
      n++;
    end while (io.state_led == l0 && n < 20);
    chk(tag, n, exp_lat);
    repeat (3) tick();
    set_btn(3'b000);
    repeat (8) tick();
  endtask

  // Reset lands mid-cycle; outputs must clear with no clock edge.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset", dut_out(), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [2:0] rm;
  int         rhold;

  initial begin
    io.sw = '0;
    set_btn(3'b000);
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("reset_state", dut_out(), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) tick();

    // Operand entry with latency from raw press
    io.sw = 4'd3;
    press_measure("lat_confirm_a", DC + 3);
    io.sw = 4'd2;
    press_measure("lat_confirm_b", DC + 3);
    chk("entry_a", io.input_a, 3);
    chk("entry_b", io.input_b, 2);
    chk("entry_en", io.enable, 1);
    chk("entry_led", io.state_led, 2);

    // Reset while running
    press(3'b001, 10);
    io.sw = 4'd5; press(3'b001, 10);
    io.sw = 4'd6; press(3'b001, 10);
    chk("run_en", io.enable, 1);
    chk("run_a", io.input_a, 5);
    async_reset();
    repeat (2) tick();

    // Bouncy confirm then a clean hold: one advance only
    io.sw = 4'd7;
    for (int k = 0; k < 5; k++) begin
      set_btn(3'b001);
      repeat (1 + (k % 2)) tick();
      set_btn(3'b000);
      repeat (3) tick();
    end
    chk("bounce_led_glitch", io.state_led, 0);
    press(3'b001, 10);
    chk("bounce_led", io.state_led, 1);
    chk("bounce_a", io.input_a, 7);

    // Op toggle in run, ignored in S_A
    io.sw = 4'd1; press(3'b001, 10);
    press(3'b010, 10); chk("op_sel1", io.select, 1);
    press(3'b010, 10); chk("op_sel0", io.select, 0);
    press(3'b010, 10); chk("op_sel1b", io.select, 1);
    press(3'b001, 10); chk("op_back_led", io.state_led, 0);
    press(3'b010, 10); chk("op_in_sa", io.select, 1);

    // Simultaneous presses
    io.sw = 4'd4; press(3'b001, 10);
    io.sw = 4'd8; press(3'b001, 10);
    press(3'b101, 10);
    chk("clr_cf_led", io.state_led, 0);
    chk("clr_cf_ops", {io.input_a, io.input_b}, 0);
    chk("clr_cf_sel", io.select, 0);
    io.sw = 4'd1; press(3'b001, 10);
    io.sw = 4'd2; press(3'b001, 10);
    press(3'b010, 10);
    press(3'b011, 10);
    chk("cf_op_led", io.state_led, 0);
    chk("cf_op_sel", io.select, 1);

    // Long hold with the switch changing after acceptance
    io.sw = 4'd1;
    set_btn(3'b001);
    repeat (10) tick();
    io.sw = 4'd9;
    repeat (40) tick();
    set_btn(3'b000);
    repeat (8) tick();
    chk("hold_a", io.input_a, 1);
    chk("hold_led", io.state_led, 1);

    // Button held across reset release gives one press
    set_btn(3'b001);
    async_reset();
    repeat (12) tick();
    set_btn(3'b000);
    repeat (8) tick();
    chk("held_rst_led", io.state_led, 1);
    chk("held_rst_a", io.input_a, 9);

    // Random traffic, glitches and presses mixed
    repeat (80) begin
      rm = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) rm[2] = 1'b0;
      io.sw = DW'($urandom);
      set_btn(rm);
      rhold = $urandom_range(1, 8);
      repeat (rhold) tick();
      if ($urandom_range(0, 1) != 0) io.sw = DW'($urandom);
      set_btn(3'b000);
      rhold = $urandom_range(1, 8);
      repeat (rhold) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
